// File: rtl/e203_ifu_predec_buf_if.sv
// Fetch-to-issue bundle of the IFU pre-decode buffer: push side, pop side and decode results.
// Latency: none, signal bundle only.
// Backpressure: i_ready toward fetch, o_ready from the consumer.
interface e203_ifu_predec_buf_if #(
  parameter int DEPTH   = 4,
  parameter int XLEN    = 32,
  parameter int PC_SIZE = 32
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // fetch side
  logic               i_valid;
  logic               i_ready;
  logic [31:0]        i_instr;
  logic [PC_SIZE-1:0] i_pc;
  logic               flush;

  // issue side
  logic               o_valid;
  logic               o_ready;
  logic [31:0]        o_instr;
  logic [PC_SIZE-1:0] o_pc;
  logic               o_rv32;
  logic               o_bjp;
  logic               o_jal;
  logic               o_jalr;
  logic               o_bxx;
  logic [XLEN-1:0]    o_bjp_imm;
  logic [4:0]         o_jalr_rs1idx;
  logic               o_prdt_taken;
  logic [PC_SIZE-1:0] o_prdt_pc;
  logic               o_muldiv;
  logic [CNT_W-1:0]   o_count;

  // master: fetch unit plus consumer (the environment around the buffer)
  modport master (
    output i_valid, i_instr, i_pc, flush, o_ready,
    input  i_ready, o_valid, o_instr, o_pc, o_rv32, o_bjp, o_jal, o_jalr, o_bxx,
           o_bjp_imm, o_jalr_rs1idx, o_prdt_taken, o_prdt_pc, o_muldiv, o_count
  );

  // slave: the buffer itself
  modport slave (
    input  i_valid, i_instr, i_pc, flush, o_ready,
    output i_ready, o_valid, o_instr, o_pc, o_rv32, o_bjp, o_jal, o_jalr, o_bxx,
           o_bjp_imm, o_jalr_rs1idx, o_prdt_taken, o_prdt_pc, o_muldiv, o_count
  );
endinterface

// File: rtl/e203_ifu_predec_buf.sv
// IFU pre-decode buffer: DEPTH-entry FIFO, mini-decode + static branch prediction at enqueue.
// Latency: 1 cycle push-to-head, registered storage, no combinational input-to-output path.
// Backpressure: i_ready = !full (no pop bypass when full); flush drops all entries and any coincident push/pop.
// Optional: define E203_IFU_PREDEC_MULDIV_EN to store and report an M-extension flag per entry.
module e203_ifu_predec_buf #(
  parameter int DEPTH   = 4,
  parameter int XLEN    = 32,
  parameter int PC_SIZE = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  e203_ifu_predec_buf_if.slave        bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // one buffer slot: raw instruction plus everything decoded from it at enqueue
  typedef struct packed {
    logic [31:0]        instr;
    logic [PC_SIZE-1:0] pc;
    logic               rv32;
    logic               jal;
    logic               jalr;
    logic               bxx;
    logic [XLEN-1:0]    imm;
    logic [4:0]         rs1;
    logic               taken;
    logic [PC_SIZE-1:0] prdt_pc;
`ifdef E203_IFU_PREDEC_MULDIV_EN
    logic               muldiv;
`endif
  } ent_t;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  ent_t             mem_q [DEPTH];

  logic full, empty, push, pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  // flush wins over both ends of the FIFO in the same cycle
  assign push  = bus.i_valid & ~full & ~bus.flush;
  assign pop   = ~empty & bus.o_ready & ~bus.flush;

  // ---------------- enqueue-side decode ----------------
  logic [31:0] ins;
  assign ins = bus.i_instr;

  logic [20:0] imm_j;
  logic [12:0] imm_b;
  logic [11:0] imm_i;
  logic [11:0] imm_cj;
  logic [8:0]  imm_cb;
  assign imm_j  = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
  assign imm_b  = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  assign imm_i  = ins[31:20];
  assign imm_cj = {ins[12], ins[8], ins[10:9], ins[6], ins[7], ins[2], ins[11], ins[5:3], 1'b0};
  assign imm_cb = {ins[12], ins[6:5], ins[2], ins[11:10], ins[4:3], 1'b0};

  logic is_rv32, rvc_q1, rvc_q2;
  logic r_jal, r_jalr, r_bxx, c_jal, c_bxx, c_jr;
  assign is_rv32 = (ins[1:0] == 2'b11);
  assign rvc_q1  = (ins[1:0] == 2'b01);
  assign rvc_q2  = (ins[1:0] == 2'b10);
  assign r_jal   = is_rv32 & (ins[6:0] == 7'b1101111);
  assign r_jalr  = is_rv32 & (ins[6:0] == 7'b1100111) & (ins[14:12] == 3'b000);
  assign r_bxx   = is_rv32 & (ins[6:0] == 7'b1100011);
  assign c_jal   = rvc_q1 & ((ins[15:13] == 3'b101) | (ins[15:13] == 3'b001));
  assign c_bxx   = rvc_q1 & ((ins[15:13] == 3'b110) | (ins[15:13] == 3'b111));
  // C.JR / C.JALR share an encoding apart from bit 12, which does not matter here
  assign c_jr    = rvc_q2 & (ins[15:13] == 3'b100) & (ins[6:2] == 5'd0) & (ins[11:7] != 5'd0);

  ent_t new_ent;

  // build the entry to enqueue: class flags, immediate, jalr source and static prediction
  always_comb begin
    new_ent       = '0;
    new_ent.instr = ins;
    new_ent.pc    = bus.i_pc;
    new_ent.rv32  = is_rv32;
    new_ent.jal   = r_jal | c_jal;
    new_ent.jalr  = r_jalr | c_jr;
    new_ent.bxx   = r_bxx | c_bxx;
    if (r_jal)       new_ent.imm = {{(XLEN-21){imm_j[20]}}, imm_j};
    else if (r_bxx)  new_ent.imm = {{(XLEN-13){imm_b[12]}}, imm_b};
    else if (r_jalr) new_ent.imm = {{(XLEN-12){imm_i[11]}}, imm_i};
    else if (c_jal)  new_ent.imm = {{(XLEN-12){imm_cj[11]}}, imm_cj};
    else if (c_bxx)  new_ent.imm = {{(XLEN-9){imm_cb[8]}}, imm_cb};
    if (r_jalr)      new_ent.rs1 = ins[19:15];
    else if (c_jr)   new_ent.rs1 = ins[11:7];
    // jal always taken, backward conditional branches taken, jalr target unknown
    new_ent.taken = new_ent.jal | (new_ent.bxx & new_ent.imm[XLEN-1]);
    if (new_ent.taken)
      new_ent.prdt_pc = bus.i_pc + new_ent.imm[PC_SIZE-1:0];
    else
      new_ent.prdt_pc = bus.i_pc + {{(PC_SIZE-3){1'b0}}, is_rv32, ~is_rv32, 1'b0};
`ifdef E203_IFU_PREDEC_MULDIV_EN
    new_ent.muldiv = is_rv32 & (ins[6:0] == 7'b0110011) & (ins[31:25] == 7'b0000001);
`endif
  end

  // ---------------- pointer / occupancy control ----------------
  // next pointers and count: flush clears, push/pop advance, push+pop keeps count
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push & ~pop)      count_d = count_q + CNT_W'(1);
      else if (pop & ~push) count_d = count_q - CNT_W'(1);
    end
  end

  // pointer and count registers; only validity state is reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // entry storage, written on accepted push, deliberately not reset
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= new_ent;
  end

  // ---------------- head outputs ----------------
  ent_t head;
  assign head = empty ? '0 : mem_q[rd_ptr_q];

  assign bus.i_ready       = ~full;
  assign bus.o_valid       = ~empty;
  assign bus.o_count       = count_q;
  assign bus.o_instr       = head.instr;
  assign bus.o_pc          = head.pc;
  assign bus.o_rv32        = head.rv32;
  assign bus.o_jal         = head.jal;
  assign bus.o_jalr        = head.jalr;
  assign bus.o_bxx         = head.bxx;
  assign bus.o_bjp         = head.jal | head.jalr | head.bxx;
  assign bus.o_bjp_imm     = head.imm;
  assign bus.o_jalr_rs1idx = head.rs1;
  assign bus.o_prdt_taken  = head.taken;
  assign bus.o_prdt_pc     = head.prdt_pc;
`ifdef E203_IFU_PREDEC_MULDIV_EN
  assign bus.o_muldiv      = head.muldiv;
`else
  assign bus.o_muldiv      = 1'b0;
`endif

endmodule

// File: tb/tb_e203_ifu_predec_buf.sv
// Bench for e203_ifu_predec_buf: directed literal cases, then random push/pop/flush traffic
// compared every cycle against a queue-based reference model with arithmetic decode.
module tb_e203_ifu_predec_buf;
  localparam int DEPTH = 4;
`ifdef E203_IFU_PREDEC_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  e203_ifu_predec_buf_if #(.DEPTH(DEPTH), .XLEN(32), .PC_SIZE(32)) bus ();

  e203_ifu_predec_buf #(.DEPTH(DEPTH), .XLEN(32), .PC_SIZE(32)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%08h, expected 0x%08h", nm, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        rv32, jal, jalr, bxx;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic        taken;
    logic [31:0] prdt_pc;
    logic        muldiv;
  } ent_t;

  ent_t mq[$];

  function automatic int fld(input logic [31:0] x, input int hi, input int lo);
    longint m;
    m = (64'd1 << (hi - lo + 1)) - 1;
    return int'((longint'(x) >> lo) & m);
  endfunction

  // interpret an n-bit two's complement field as a signed integer
  function automatic int sx(input int v, input int n);
    return (v ^ (1 << (n - 1))) - (1 << (n - 1));
  endfunction

  function automatic ent_t model_dec(input logic [31:0] ins, input logic [31:0] pc);
    ent_t e;
    int imm, op, f3, q;
    e = '0;
    imm = 0;
    e.instr = ins;
    e.pc = pc;
    q = fld(ins, 1, 0);
    e.rv32 = (q == 3);
    if (e.rv32) begin
      op = fld(ins, 6, 0);
      f3 = fld(ins, 14, 12);
      if (op == 'h6f) begin
        e.jal = 1;
        imm = sx((fld(ins,31,31) << 20) | (fld(ins,19,12) << 12) | (fld(ins,20,20) << 11) | (fld(ins,30,21) << 1), 21);
      end else if (op == 'h67 && f3 == 0) begin
        e.jalr = 1;
        e.rs1 = 5'(fld(ins, 19, 15));
        imm = sx(fld(ins, 31, 20), 12);
      end else if (op == 'h63) begin
        e.bxx = 1;
        imm = sx((fld(ins,31,31) << 12) | (fld(ins,7,7) << 11) | (fld(ins,30,25) << 5) | (fld(ins,11,8) << 1), 13);
      end
      e.muldiv = MD_EN && op == 'h33 && fld(ins, 31, 25) == 1;
    end else begin
      f3 = fld(ins, 15, 13);
      if (q == 1 && (f3 == 5 || f3 == 1)) begin
        e.jal = 1;
        imm = sx((fld(ins,12,12) << 11) | (fld(ins,8,8) << 10) | (fld(ins,10,9) << 8) | (fld(ins,6,6) << 7) |
                 (fld(ins,7,7) << 6) | (fld(ins,2,2) << 5) | (fld(ins,11,11) << 4) | (fld(ins,5,3) << 1), 12);
      end else if (q == 1 && (f3 == 6 || f3 == 7)) begin
        e.bxx = 1;
        imm = sx((fld(ins,12,12) << 8) | (fld(ins,6,5) << 6) | (fld(ins,2,2) << 5) | (fld(ins,11,10) << 3) |
                 (fld(ins,4,3) << 1), 9);
      end else if (q == 2 && f3 == 4 && fld(ins, 6, 2) == 0 && fld(ins, 11, 7) != 0) begin
        e.jalr = 1;
        e.rs1 = 5'(fld(ins, 11, 7));
      end
    end
    e.imm = 32'(imm);
    e.taken = e.jal || (e.bxx && imm < 0);
    e.prdt_pc = e.taken ? pc + 32'(imm) : pc + (e.rv32 ? 32'd4 : 32'd2);
    return e;
  endfunction

  // model state update on each clock edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
    end else if (bus.flush) begin
      mq.delete();
    end else begin
      bit was_full;
      was_full = (mq.size() >= DEPTH);
      if (mq.size() != 0 && bus.o_ready) void'(mq.pop_front());
      if (bus.i_valid && !was_full) mq.push_back(model_dec(bus.i_instr, bus.i_pc));
    end
  end

  // per-cycle comparison on the falling edge
  always @(negedge clk) begin
    if (rst_n) begin
      ent_t e;
      e = (mq.size() == 0) ? '0 : mq[0];
      chk("o_valid", 32'(bus.o_valid), 32'(mq.size() != 0));
      chk("i_ready", 32'(bus.i_ready), 32'(mq.size() < DEPTH));
      chk("o_count", 32'(bus.o_count), 32'(mq.size()));
      chk("o_instr", bus.o_instr, e.instr);
      chk("o_pc", bus.o_pc, e.pc);
      chk("o_rv32", 32'(bus.o_rv32), 32'(e.rv32));
      chk("o_jal", 32'(bus.o_jal), 32'(e.jal));
      chk("o_jalr", 32'(bus.o_jalr), 32'(e.jalr));
      chk("o_bxx", 32'(bus.o_bxx), 32'(e.bxx));
      chk("o_bjp", 32'(bus.o_bjp), 32'(e.jal | e.jalr | e.bxx));
      chk("o_bjp_imm", bus.o_bjp_imm, e.imm);
      chk("o_jalr_rs1idx", 32'(bus.o_jalr_rs1idx), 32'(e.rs1));
      chk("o_prdt_taken", 32'(bus.o_prdt_taken), 32'(e.taken));
      chk("o_prdt_pc", bus.o_prdt_pc, e.prdt_pc);
      chk("o_muldiv", 32'(bus.o_muldiv), 32'(e.muldiv));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [31:0] ins, input logic [31:0] pc);
    bus.i_valid = 1'b1;
    bus.i_instr = ins;
    bus.i_pc    = pc;
    cyc();
    bus.i_valid = 1'b0;
  endtask

  task automatic pop1();
    bus.o_ready = 1'b1;
    cyc();
    bus.o_ready = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [2:0]  f3;
    r = $urandom;
    f3 = 3'($urandom_range(0, 7));
    case ($urandom_range(0, 9))
      0: return {r[31:7], 7'b1101111};
      1: return {r[31:15], 3'b000, r[11:7], 7'b1100111};
      2: return {r[31:15], f3, r[11:7], 7'b1100111};
      3: return {r[31:7], 7'b1100011};
      4: return {r[31:16], f3, r[12:2], 2'b01};
      5: return {r[31:16], 3'b100, r[12], r[11:7], 5'd0, 2'b10};
      6: return {r[31:16], 3'b100, r[12], (r[3] ? 5'd0 : r[11:7]), (r[4] ? r[6:2] : 5'd0), 2'b10};
      7: return {7'b0000001, r[24:7], 7'b0110011};
      8: return {r[31:16], f3, r[12:2], 2'b00};
      default: return r;
    endcase
  endfunction

  initial begin
    bus.i_valid = 1'b0;
    bus.i_instr = '0;
    bus.i_pc    = '0;
    bus.flush   = 1'b0;
    bus.o_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // reset state
    chk("reset i_ready", 32'(bus.i_ready), 32'd1);
    chk("reset o_valid", 32'(bus.o_valid), 32'd0);
    chk("reset o_count", 32'(bus.o_count), 32'd0);
    chk("reset o_instr", bus.o_instr, 32'd0);

    // jal x0,-8 @0x100
    push1(32'hFF9FF06F, 32'h100);
    chk("jal o_jal", 32'(bus.o_jal), 32'd1);
    chk("jal taken", 32'(bus.o_prdt_taken), 32'd1);
    chk("jal prdt_pc", bus.o_prdt_pc, 32'h0F8);
    chk("jal imm", bus.o_bjp_imm, 32'hFFFFFFF8);
    pop1();

    // beq +16 and beq -16 @0x200
    push1(32'h00000863, 32'h200);
    chk("beq+ o_bxx", 32'(bus.o_bxx), 32'd1);
    chk("beq+ taken", 32'(bus.o_prdt_taken), 32'd0);
    chk("beq+ prdt_pc", bus.o_prdt_pc, 32'h204);
    pop1();
    push1(32'hFE0008E3, 32'h200);
    chk("beq- taken", 32'(bus.o_prdt_taken), 32'd1);
    chk("beq- prdt_pc", bus.o_prdt_pc, 32'h1F0);
    pop1();

    // C.JR x5 @0x300
    push1(32'h00008282, 32'h300);
    chk("c.jr rv32", 32'(bus.o_rv32), 32'd0);
    chk("c.jr jalr", 32'(bus.o_jalr), 32'd1);
    chk("c.jr rs1", 32'(bus.o_jalr_rs1idx), 32'd5);
    chk("c.jr taken", 32'(bus.o_prdt_taken), 32'd0);
    chk("c.jr prdt_pc", bus.o_prdt_pc, 32'h302);
    pop1();

    // mul x1,x2,x3
    push1(32'h023100B3, 32'h380);
    chk("mul muldiv", 32'(bus.o_muldiv), 32'(MD_EN));
    chk("mul bjp", 32'(bus.o_bjp), 32'd0);
    pop1();

    // fill to full with pointers not at zero, then try a 5th push
    bus.i_instr = 32'h00000013;
    bus.i_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.i_pc = 32'h400 + 32'(4 * k);
      cyc();
    end
    chk("full i_ready", 32'(bus.i_ready), 32'd0);
    chk("full count", 32'(bus.o_count), 32'd4);
    bus.i_pc = 32'h410;
    cyc();
    chk("full reject count", 32'(bus.o_count), 32'd4);
    // pop while full with push asserted: no bypass, count drops
    bus.i_pc = 32'h500;
    bus.o_ready = 1'b1;
    cyc();
    bus.i_valid = 1'b0;
    chk("full pop no-bypass count", 32'(bus.o_count), 32'd3);
    for (int k = 1; k < 4; k++) begin
      chk("drain order pc", bus.o_pc, 32'h400 + 32'(4 * k));
      cyc();
    end
    bus.o_ready = 1'b0;
    chk("drained o_valid", 32'(bus.o_valid), 32'd0);

    // simultaneous push+pop at count 2
    push1(32'h00000013, 32'h600);
    push1(32'h00000013, 32'h604);
    bus.i_valid = 1'b1;
    bus.i_pc = 32'h608;
    bus.o_ready = 1'b1;
    cyc();
    bus.o_ready = 1'b0;
    chk("push+pop count", 32'(bus.o_count), 32'd2);
    chk("push+pop head pc", bus.o_pc, 32'h604);
    // flush with a push pending
    bus.flush = 1'b1;
    bus.i_pc = 32'h60C;
    cyc();
    bus.flush = 1'b0;
    bus.i_valid = 1'b0;
    chk("flush count", 32'(bus.o_count), 32'd0);
    chk("flush o_valid", 32'(bus.o_valid), 32'd0);

    // random traffic checked by the per-cycle model comparison
    for (int c = 0; c < 3000; c++) begin
      bus.i_valid = ($urandom_range(0, 99) < 70);
      bus.i_instr = rand_instr();
      bus.i_pc    = {$urandom_range(0, 32'hFFFF), 16'h0} | 32'(($urandom_range(0, 16'hFFFF)) & 16'hFFFE);
      bus.o_ready = ($urandom_range(0, 99) < 55);
      bus.flush   = ($urandom_range(0, 99) < 3);
      cyc();
    end
    bus.i_valid = 1'b0;
    bus.flush   = 1'b0;
    bus.o_ready = 1'b1;
    repeat (DEPTH + 2) cyc();
    chk("final empty", 32'(bus.o_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
